// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Control FSM for the multicycle MIPS datapath. Sequences each
//               instruction through fetch/decode/execute/memory/writeback,
//               drives datapath selects and write enables, and stalls on the
//               memory-ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       retire,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state;
  state_t state_next;

  // Enables decoded from state before the reset gate is applied
  logic pcwrite;
  logic branch;
  logic mem_req_raw;
  logic irwrite_raw;
  logic memwrite_raw;
  logic regwrite_raw;
  logic retire_raw;
  logic illegal_raw;

  // State register; reset forces FETCH immediately, independent of the clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state and Moore output decode, with mem_ready gating on memory states
  always_comb begin
    state_next   = S_FETCH;
    mem_req_raw  = 1'b0;
    iord         = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    aluop        = 2'b00;
    pcsrc        = 2'b00;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    retire_raw   = 1'b0;
    illegal_raw  = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req_raw = 1'b1;
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pcwrite     = mem_ready;
        state_next  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut
        alusrcb = 2'b11;
        case (op)
          OP_RTYPE:      state_next = S_RTYPEEX;
          OP_LW, OP_SW:  state_next = S_MEMADR;
          OP_BEQ:        state_next = S_BEQEX;
          OP_ADDI:       state_next = S_ADDIEX;
          OP_J:          state_next = S_JEX;
          default: begin
            state_next  = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req_raw = 1'b1;
        iord        = 1'b1;
        state_next  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        retire_raw   = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_raw  = 1'b1;
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        retire_raw   = mem_ready;
        state_next   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b10;
        state_next = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        retire_raw   = 1'b1;
        state_next   = S_FETCH;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        retire_raw = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
        retire_raw   = 1'b1;
        state_next   = S_FETCH;
      end
      S_JEX: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        retire_raw = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Reset masks every enable at once, so an aborted store never writes
  assign mem_req  = mem_req_raw  & ~reset;
  assign irwrite  = irwrite_raw  & ~reset;
  assign memwrite = memwrite_raw & ~reset;
  assign regwrite = regwrite_raw & ~reset;
  assign retire   = retire_raw   & ~reset;
  assign illegal  = illegal_raw  & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. An instruction-level
//               reference model expands each instruction into its expected
//               per-cycle control outputs and input drive values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, iord, irwrite, memwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pcen, regdst, memtoreg, regwrite, retire, illegal;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       retire;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic       mr;
    logic       z;
    logic [5:0] opv;
    outs_t      exp;
  } cyc_t;

  cyc_t  q[$];
  outs_t act;
  int    n_checks;
  int    n_fail;

  assign act = {mem_req, iord, irwrite, memwrite, alusrca, alusrcb, aluop,
                pcsrc, pcen, regdst, memtoreg, regwrite, retire, illegal};

  multicycle_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .zero     (zero),
    .mem_ready(mem_ready),
    .mem_req  (mem_req),
    .iord     (iord),
    .irwrite  (irwrite),
    .memwrite (memwrite),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .aluop    (aluop),
    .pcsrc    (pcsrc),
    .pcen     (pcen),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .retire   (retire),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic mr, input logic z, input logic [5:0] o,
                               input outs_t e);
    cyc_t c;
    c.mr = mr; c.z = z; c.opv = o; c.exp = e;
    q.push_back(c);
  endfunction

  // Expected outputs while reset is held: no enables, FETCH mux values
  function automatic outs_t reset_outs();
    outs_t e = '0;
    e.alusrcb = 2'b01;
    return e;
  endfunction

  // Reference model: expands one instruction into its cycle-by-cycle behaviour
  task automatic model_instr(input logic [5:0] o, input logic z,
                             input int fstall, input int mstall);
    outs_t e;
    for (int i = 0; i < fstall; i++) begin
      e = '0; e.mem_req = 1; e.alusrcb = 2'b01;
      push(1'b0, rb(), 6'($urandom), e);
    end
    e = '0; e.mem_req = 1; e.alusrcb = 2'b01; e.irwrite = 1; e.pcen = 1;
    push(1'b1, rb(), 6'($urandom), e);
    e = '0; e.alusrcb = 2'b11;
    case (o)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010: ;
      default: begin
        e.illegal = 1;
        push(rb(), rb(), o, e);
        return;
      end
    endcase
    push(rb(), rb(), o, e);
    case (o)
      6'b100011, 6'b101011: begin
        e = '0; e.alusrca = 1; e.alusrcb = 2'b10;
        push(rb(), rb(), o, e);
        for (int i = 0; i <= mstall; i++) begin
          e = '0; e.mem_req = 1; e.iord = 1;
          if (o == 6'b101011) begin
            e.memwrite = 1;
            e.retire = (i == mstall);
          end
          push(i == mstall, rb(), o, e);
        end
        if (o == 6'b100011) begin
          e = '0; e.memtoreg = 1; e.regwrite = 1; e.retire = 1;
          push(rb(), rb(), o, e);
        end
      end
      6'b000000: begin
        e = '0; e.alusrca = 1; e.aluop = 2'b10;
        push(rb(), rb(), o, e);
        e = '0; e.regdst = 1; e.regwrite = 1; e.retire = 1;
        push(rb(), rb(), o, e);
      end
      6'b001000: begin
        e = '0; e.alusrca = 1; e.alusrcb = 2'b10;
        push(rb(), rb(), o, e);
        e = '0; e.regwrite = 1; e.retire = 1;
        push(rb(), rb(), o, e);
      end
      6'b000100: begin
        e = '0; e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01;
        e.pcen = z; e.retire = 1;
        push(rb(), z, o, e);
      end
      default: begin
        e = '0; e.pcsrc = 2'b10; e.pcen = 1; e.retire = 1;
        push(rb(), rb(), o, e);
      end
    endcase
  endtask

  // Plays queued cycles (n < 0 means all); entered and left at posedge+1
  task automatic run_queue(input string name, input int n);
    cyc_t c;
    int   k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      c = q.pop_front();
      mem_ready = c.mr; zero = c.z; op = c.opv;
      @(negedge clk);
      n_checks++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: actual %h required %h", name, k, act, c.exp);
      end
      n_checks++;
      if ((retire & illegal) !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_retire_illegal cycle %0d: actual %b required 0", name, k,
                 retire & illegal);
      end
      @(posedge clk); #1;
      k++;
    end
    q.delete();
  endtask

  task automatic test_reset();
    reset = 1; mem_ready = 0; zero = 0; op = 6'b100011;
    @(negedge clk);
    n_checks++;
    if (act !== reset_outs()) begin
      n_fail++; $display("FAIL reset_idle: actual %h required %h", act, reset_outs());
    end
    mem_ready = 1; zero = 1; #1;
    n_checks++;
    if (act !== reset_outs()) begin
      n_fail++; $display("FAIL reset_ready: actual %h required %h", act, reset_outs());
    end
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_lw();
    model_instr(6'b100011, 1'b0, 0, 0);
    run_queue("lw", -1);
  endtask

  task automatic test_sw_stall();
    model_instr(6'b101011, 1'b0, 0, 3);
    run_queue("sw_stall", -1);
  endtask

  task automatic test_beq();
    model_instr(6'b000100, 1'b1, 0, 0);
    run_queue("beq_taken", -1);
    model_instr(6'b000100, 1'b0, 0, 0);
    run_queue("beq_not_taken", -1);
  endtask

  task automatic test_back_to_back();
    model_instr(6'b000000, 1'b0, 0, 0);
    model_instr(6'b001000, 1'b0, 0, 0);
    model_instr(6'b000010, 1'b0, 0, 0);
    run_queue("back_to_back", -1);
  endtask

  task automatic test_illegal();
    model_instr(6'b111111, 1'b0, 0, 0);
    model_instr(6'b000000, 1'b0, 0, 0);
    run_queue("illegal", -1);
  endtask

  task automatic test_fetch_stall();
    model_instr(6'b001000, 1'b0, 2, 0);
    run_queue("fetch_stall", -1);
  endtask

  task automatic test_reset_midwrite();
    outs_t e;
    model_instr(6'b101011, 1'b0, 0, 3);
    run_queue("midwrite_pre", 4);
    mem_ready = 0; op = 6'b101011; #1;
    e = '0; e.mem_req = 1; e.iord = 1; e.memwrite = 1;
    n_checks++;
    if (act !== e) begin
      n_fail++; $display("FAIL midwrite_hold: actual %h required %h", act, e);
    end
    reset = 1; #1;
    n_checks++;
    if (act !== reset_outs()) begin
      n_fail++; $display("FAIL midwrite_abort: actual %h required %h", act, reset_outs());
    end
    mem_ready = 1;
    @(negedge clk);
    n_checks++;
    if (act !== reset_outs()) begin
      n_fail++; $display("FAIL midwrite_abort_ready: actual %h required %h", act,
                         reset_outs());
    end
    @(posedge clk); #1;
    reset = 0; mem_ready = 0;
    e = '0; e.mem_req = 1; e.alusrcb = 2'b01;
    @(negedge clk);
    n_checks++;
    if (act !== e) begin
      n_fail++; $display("FAIL midwrite_refetch: actual %h required %h", act, e);
    end
    @(posedge clk); #1;
    model_instr(6'b100011, 1'b0, 1, 1);
    run_queue("after_abort_lw", -1);
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
    ops[4] = 6'b001000; ops[5] = 6'b000010; ops[6] = 6'b111111;
    for (int i = 0; i < 40; i++) begin
      logic [5:0] o;
      o = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      model_instr(o, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    run_queue("random", -1);
  endtask

  // Hard time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Test sequence
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_fetch_stall();
    test_reset_midwrite();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multicycle MIPS datapath: one shared ALU, a unified instruction/data memory, and an instruction register. It sequences each instruction through fetch, decode, execute, memory and writeback. Every cycle it drives the datapath mux selects and write enables, and it stalls on a memory-ready handshake. It sits beside the datapath in the multicycle top and takes the place of the single-cycle main/ALU-op decode path.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `op`  in  6  opcode, instr[31:26] from the instruction register
- `zero`  in  1  ALU zero flag, combinational from the datapath
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access request
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `irwrite`  out  1  instruction register load
- `memwrite`  out  1  memory write
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = regA
- `alusrcb`  out  2  ALU B select: 00 = regB, 01 = const 4, 10 = signimm, 11 = signimm<<2
- `aluop`  out  2  00 add, 01 sub, 10 use funct
- `pcsrc`  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- `pcen`  out  1  PC write enable, equal to `pcwrite | (branch & zero)`
- `regdst`  out  1  register write address select: 0 = rt, 1 = rd
- `memtoreg`  out  1  register write data select: 0 = ALUOut, 1 = memory data
- `regwrite`  out  1  register file write
- `retire`  out  1  one-cycle pulse when an instruction completes
- `illegal`  out  1  one-cycle pulse when an unknown opcode is decoded

## Operation
- States use a 4-bit encoding: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- Outputs are decoded from state only (Moore), apart from the gating by `mem_ready`/`zero` noted below. Any output not listed for a state is 0.
  - FETCH: `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00. `irwrite` and `pcwrite` equal `mem_ready`.
  - DECODE: `alusrca`=0, `alusrcb`=11, `aluop`=00, which precomputes the branch target.
  - MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=00.
  - MEMRD: `mem_req`=1, `iord`=1.
  - MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1.
  - MEMWR: `mem_req`=1, `iord`=1, `memwrite`=1.
  - RTYPEEX: `alusrca`=1, `alusrcb`=00, `aluop`=10.
  - RTYPEWB: `regdst`=1, `regwrite`=1.
  - BEQEX: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcsrc`=01, `branch`=1.
  - ADDIEX: `alusrca`=1, `alusrcb`=10, `aluop`=00.
  - ADDIWB: `regdst`=0, `regwrite`=1.
  - JEX: `pcsrc`=10, `pcwrite`=1.
- Transitions:
  - FETCH → DECODE when `mem_ready`; otherwise hold.
  - DECODE goes by `op`:
    - 000000 → RTYPEEX
    - 100011 or 101011 → MEMADR
    - 000100 → BEQEX
    - 001000 → ADDIEX
    - 000010 → JEX
    - any other value → FETCH, with `illegal`=1 for that cycle.
  - MEMADR → MEMRD for `op`=100011, otherwise MEMWR.
  - MEMRD → MEMWB when `mem_ready`; otherwise hold.
  - MEMWR → FETCH when `mem_ready`; otherwise hold. `memwrite` stays asserted while holding.
  - RTYPEEX → RTYPEWB; ADDIEX → ADDIWB.
  - MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX → FETCH.
- `retire`=1 on the last cycle of every instruction: MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX, and MEMWR when `mem_ready`.
- `op` is sampled only in DECODE and MEMADR. `op` is stable there because the instruction register loads only in FETCH.
- An undefined state encoding → FETCH on the next clock.

## Timing
- While `reset`=1:
  - state is forced to FETCH asynchronously;
  - `mem_req`, `irwrite`, `memwrite`, `pcen`, `regwrite`, `retire`, `illegal` are 0;
  - mux selects take their FETCH values (`iord`=0, `alusrcb`=01, others 0).
- The first FETCH cycle is the first rising edge after `reset` deasserts.
- Reset asserted mid-instruction aborts it immediately. No write enables are asserted after the reset edge, including a pending MEMWR.
- Cycles per instruction with `mem_ready` held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_ready` is ignored in every other state.
- `pcen` in BEQEX follows `zero` combinationally in the same cycle.
- Exactly one `retire` pulse per completed instruction. `retire` and `illegal` are never both high.

## Test plan
- Reset then lw (`op`=100011), `mem_ready`=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `regwrite`=1 and `memtoreg`=1 only in cycle 5; `retire` in cycle 5.
- sw (`op`=101011) with `mem_ready` low for 3 cycles in MEMWR: `memwrite`=1 for 4 consecutive cycles; FETCH on the cycle after `mem_ready` rises; 7 cycles total.
- beq (`op`=000100) with `zero`=1, then with `zero`=0: `pcen`=1 in BEQEX for the first case only, `pcsrc`=01 in both; 3 cycles each.
- R-type, addi (001000), j (000010) back to back, `mem_ready`=1: 4, 4 and 3 cycles. `regdst`=1 in RTYPEWB, 0 in ADDIWB. `pcsrc`=10 and `pcen`=1 in JEX.
- `op`=111111: `illegal` pulses once in DECODE, next state is FETCH, no `retire` and no write enables.
- Fetch stall: `mem_ready`=0 for 2 cycles in FETCH, so `irwrite` and `pcen` stay 0. Then assert `reset` during MEMWR: all enables drop the same cycle and the state reads FETCH after `reset` deasserts.
